regfile_req_initiator: RTL and testbench
========================================

Name: regfile_req_initiator

Overview:
- Clocked initiator for the register file's req/ack four-phase handshake; drives the rf_* side of that interface.
- Accepts one register-file command at a time from an upstream pipeline stage over valid/ready.
- Sequences req high, ack high, req low, ack low.
- Captures both read ports and returns them, plus a timeout flag, on a valid/ready response channel.

Parameters:
- DataWidth, 16, width of data words.
- AddrWidth, 4, width of register addresses.
- TimeoutCycles, 64, max cycles waited per ack phase; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  upstream command valid.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  input  1  command is a write.
- cmd_addr_w  input  AddrWidth  write address.
- cmd_addr_r1  input  AddrWidth  read address 1.
- cmd_addr_r2  input  AddrWidth  read address 2.
- cmd_data  input  DataWidth  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts response.
- rsp_data1  output  DataWidth  captured read data 1.
- rsp_data2  output  DataWidth  captured read data 2.
- rsp_timeout  output  1  this transaction timed out.
- rf_req  output  1  handshake request to the register file.
- rf_ack  input  1  handshake acknowledge from the register file; same clk domain, registered at source.
- rf_we, rf_addr_w, rf_addr_r1, rf_addr_r2, rf_data_in  output  1/AddrWidth/AddrWidth/AddrWidth/DataWidth  command fields to the register file.
- rf_data_out1, rf_data_out2  input  DataWidth  combinational read data from the register file.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; rf_req=0; all rf_* command outputs 0; rsp_valid=0; rsp_data1/2=0; rsp_timeout=0; timeout counter 0.
- FSM states: IDLE, REQ_HI, REQ_LO, RESP.
- All outputs are registered. cmd_ready and busy are decoded from state and rf_ack only.
- IDLE:
  - cmd_ready = !rf_ack. No command is accepted while a stale ack is still high.
  - On accept: latch all cmd_* fields into rf_* outputs, set rf_req=1, clear counter and rsp_timeout, go to REQ_HI.
- REQ_HI:
  - Waits for rf_ack=1.
  - On rf_ack=1: capture rf_data_out1/2 into rsp_data1/2 on that edge, set rf_req=0, go to REQ_LO.
  - Read data is sampled after the register file's write edge, so a read of addr_w returns the new value.
- REQ_LO:
  - Waits for rf_ack=0, then goes to RESP with rsp_valid=1.
- RESP:
  - Holds rsp_* stable until rsp_valid && rsp_ready, then clears rsp_valid and goes to IDLE.
  - Response and new-command acceptance never overlap in the same cycle.
- rf_we/addr/data outputs stay stable from accept until the RESP->IDLE edge.
- Nominal latency against the register file's one-cycle ack response:
  - accept at edge E0; rf_req=1 after E0; rf_ack=1 after E1.
  - capture and rf_req=0 at E2; rf_ack=0 after E3.
  - rsp_valid=1 after E4.
  - With rsp_ready held high, the next cmd_ready=1 follows after E5.
- Timeout (TimeoutCycles>0):
  - The counter increments each cycle spent in REQ_HI or REQ_LO and resets on each state change.
  - In REQ_HI, counter==TimeoutCycles-1 with no ack: set rf_req=0, rsp_data1/2=0, rsp_timeout=1, go to REQ_LO.
  - In REQ_LO, the same condition with ack still high: set rsp_timeout=1, go to RESP. IDLE then holds cmd_ready low until ack falls.
- Simultaneous events:
  - rf_ack rising on the same edge a timeout would fire: ack wins, no timeout.
  - cmd_valid while busy: ignored, cmd_ready=0.
- Reset mid-operation: rf_req drops immediately. The responder may still hold ack high. After reset release, IDLE blocks acceptance until rf_ack=0.
- Reads with cmd_we=0 are a full handshake; the register file is not modified.

Test Plan:
- Write then read: cmd_we=1, addr_w=3, data=16'hBEEF, then cmd_we=0, addr_r1=3, addr_r2=0 -> second response has rsp_data1=16'hBEEF, rsp_data2=0; rsp_valid 4 cycles after each accept; rsp_timeout=0.
- Write with readback of the same address: cmd_we=1, addr_w=5, addr_r1=5, data=16'h1234 -> rsp_data1=16'h1234 in the same transaction.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stay stable; cmd_ready=0; rf_req=0 throughout; accepted one cycle after rsp_ready=1.
- Ack timeout: stub rf_ack tied 0, TimeoutCycles=8 -> rf_req high exactly 8 cycles, then response with rsp_timeout=1, rsp_data1/2=0.
- Stuck ack: stub asserts ack and never drops it -> RESP with rsp_timeout=1; next cmd_valid not accepted until ack=0.
- Reset mid-handshake: assert rst_n=0 in REQ_HI after ack=1 -> rf_req=0 at once, all outputs 0; after release, cmd_ready stays 0 until rf_ack falls, then the next command completes normally.

Source files
------------

// File: rtl/regfile_req_initiator.sv
// regfile_req_initiator
// Clocked initiator for the register file's four-phase req/ack handshake.
// Takes one command at a time over valid/ready, then raises req, waits for
// ack, drops req and waits for ack to fall. It captures both read ports
// while ack is high and returns them, with a timeout flag, on a valid/ready
// response channel.
module regfile_req_initiator #(
  parameter int DataWidth     = 16,
  parameter int AddrWidth     = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // upstream command channel
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [AddrWidth-1:0] cmd_addr_w,
  input  logic [AddrWidth-1:0] cmd_addr_r1,
  input  logic [AddrWidth-1:0] cmd_addr_r2,
  input  logic [DataWidth-1:0] cmd_data,
  // downstream response channel
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_data1,
  output logic [DataWidth-1:0] rsp_data2,
  output logic                 rsp_timeout,
  // register file handshake side
  output logic                 rf_req,
  input  logic                 rf_ack,
  output logic                 rf_we,
  output logic [AddrWidth-1:0] rf_addr_w,
  output logic [AddrWidth-1:0] rf_addr_r1,
  output logic [AddrWidth-1:0] rf_addr_r2,
  output logic [DataWidth-1:0] rf_data_in,
  input  logic [DataWidth-1:0] rf_data_out1,
  input  logic [DataWidth-1:0] rf_data_out2,
  output logic                 busy
);

  // Counter only needs to reach TimeoutCycles-1; keep at least one bit so
  // the design still elaborates when the timeout is disabled.
  localparam int                CntWidth  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
  localparam bit                TimeoutEn = (TimeoutCycles > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_r;
  logic [CntWidth-1:0] cnt_r;
  logic                cnt_last_s;

  // Last permitted wait cycle of the current ack phase.
  assign cnt_last_s = TimeoutEn && (cnt_r == CntLast);

  // Acceptance is blocked while a stale ack from an earlier transaction is still high.
  assign cmd_ready = (state_r == IDLE) && !rf_ack;
  assign busy      = (state_r != IDLE);

  // Handshake sequencer: state, per-phase wait counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CntWidth{1'b0}};
      rf_req      <= 1'b0;
      rf_we       <= 1'b0;
      rf_addr_w   <= {AddrWidth{1'b0}};
      rf_addr_r1  <= {AddrWidth{1'b0}};
      rf_addr_r2  <= {AddrWidth{1'b0}};
      rf_data_in  <= {DataWidth{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_data1   <= {DataWidth{1'b0}};
      rsp_data2   <= {DataWidth{1'b0}};
      rsp_timeout <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && !rf_ack) begin
            rf_we       <= cmd_we;
            rf_addr_w   <= cmd_addr_w;
            rf_addr_r1  <= cmd_addr_r1;
            rf_addr_r2  <= cmd_addr_r2;
            rf_data_in  <= cmd_data;
            rf_req      <= 1'b1;
            rsp_timeout <= 1'b0;
            cnt_r       <= {CntWidth{1'b0}};
            state_r     <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (rf_ack) begin
            // Ack is checked first so an ack arriving on the last wait
            // cycle still completes the transfer normally.
            rsp_data1 <= rf_data_out1;
            rsp_data2 <= rf_data_out2;
            rf_req    <= 1'b0;
            cnt_r     <= {CntWidth{1'b0}};
            state_r   <= REQ_LO;
          end else if (cnt_last_s) begin
            rf_req      <= 1'b0;
            rsp_data1   <= {DataWidth{1'b0}};
            rsp_data2   <= {DataWidth{1'b0}};
            rsp_timeout <= 1'b1;
            cnt_r       <= {CntWidth{1'b0}};
            state_r     <= REQ_LO;
          end else begin
            cnt_r <= cnt_r + CntWidth'(1'b1);
          end
        end
        REQ_LO: begin
          if (!rf_ack) begin
            rsp_valid <= 1'b1;
            cnt_r     <= {CntWidth{1'b0}};
            state_r   <= RESP;
          end else if (cnt_last_s) begin
            // Ack stuck high: report it; IDLE keeps cmd_ready low until ack falls.
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            cnt_r       <= {CntWidth{1'b0}};
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r + CntWidth'(1'b1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          rf_req    <= 1'b0;
          rsp_valid <= 1'b0;
          cnt_r     <= {CntWidth{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_req_initiator.sv
// tb_regfile_req_initiator
// Directed bench for regfile_req_initiator with a small register-file
// responder model. Expected responses are queued when a command is sent
// and compared when the response appears.
module tb_regfile_req_initiator;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int TO = 8;

  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_STUCK  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr_w, cmd_addr_r1, cmd_addr_r2;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic          rf_req;
  logic          rf_ack = 1'b0;
  logic          rf_we;
  logic [AW-1:0] rf_addr_w, rf_addr_r1, rf_addr_r2;
  logic [DW-1:0] rf_data_in, rf_data_out1, rf_data_out2;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          to;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] rf_mem [16];
  bit            mem_init_done = 1'b0;
  int            mode = M_NORMAL;
  int            ack_delay = 0;
  int            dly_cnt = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            hs_cyc = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  regfile_req_initiator #(
    .DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr_w(cmd_addr_w), .cmd_addr_r1(cmd_addr_r1), .cmd_addr_r2(cmd_addr_r2),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_timeout(rsp_timeout),
    .rf_req(rf_req), .rf_ack(rf_ack), .rf_we(rf_we),
    .rf_addr_w(rf_addr_w), .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
    .rf_data_in(rf_data_in), .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2),
    .busy(busy)
  );

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Register file responder: writes on the req edge, acks after ack_delay cycles.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
      mem_init_done <= 1'b1;
    end else begin
      case (mode)
        M_NORMAL: begin
          if (rf_req && !rf_ack) begin
            if (dly_cnt >= ack_delay) begin
              if (rf_we) rf_mem[rf_addr_w] <= rf_data_in;
              rf_ack  <= 1'b1;
              dly_cnt <= 0;
            end else begin
              dly_cnt <= dly_cnt + 1;
            end
          end else begin
            dly_cnt <= 0;
            if (!rf_req) rf_ack <= 1'b0;
          end
        end
        M_NOACK: rf_ack <= 1'b0;
        M_STUCK: begin
          if (rf_req && !rf_ack) begin
            if (rf_we) rf_mem[rf_addr_w] <= rf_data_in;
            rf_ack <= 1'b1;
          end
        end
        default: rf_ack <= 1'b0;
      endcase
    end
  end

  assign rf_data_out1 = rf_mem[rf_addr_r1];
  assign rf_data_out2 = rf_mem[rf_addr_r2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic to);
    exp_t e;
    e.d1 = d1;
    e.d2 = d2;
    e.to = to;
    sb.push_back(e);
  endtask

  task automatic send(input logic we, input logic [AW-1:0] aw, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_we      = we;
    cmd_addr_w  = aw;
    cmd_addr_r1 = r1;
    cmd_addr_r2 = r2;
    cmd_data    = d;
    cmd_valid   = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    check("req_after_accept", rf_req, 1'b1);
    check("busy_after_accept", busy, 1'b1);
    check("rf_we", rf_we, we);
    check("rf_addr_w", rf_addr_w, aw);
    check("rf_addr_r1", rf_addr_r1, r1);
    check("rf_addr_r2", rf_addr_r2, r2);
    check("rf_data_in", rf_data_in, d);
  endtask

  task automatic get_rsp(input int exp_lat, input logic exp_rdy, input int hold);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_bound", 32'(n < 100), 32'd1);
    check("rsp_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    check("rsp_data1", rsp_data1, e.d1);
    check("rsp_data2", rsp_data2, e.d2);
    check("rsp_timeout", rsp_timeout, e.to);
    check("rf_req_in_resp", rf_req, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data1", rsp_data1, e.d1);
      check("hold_data2", rsp_data2, e.d2);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_rf_req", rf_req, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc    = cyc;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("busy_after_rsp", busy, 1'b0);
    check("cmd_ready_after_rsp", cmd_ready, exp_rdy);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed test sequence.
  initial begin
    int hi;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_addr_w  = '0;
    cmd_addr_r1 = '0;
    cmd_addr_r2 = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rf_req", rf_req, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data1", rsp_data1, 16'h0000);
    check("rst_rsp_data2", rsp_data2, 16'h0000);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_addr_w", rf_addr_w, 4'h0);
    check("rst_rf_data_in", rf_data_in, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Write 3 <- BEEF
    model_mem[3] = 16'hBEEF;
    push_exp(model_mem[0], model_mem[0], 1'b0);
    send(1'b1, 4'd3, 4'd0, 4'd0, 16'hBEEF);
    get_rsp(4, 1'b1, 0);

    // Read back 3 and 0
    push_exp(model_mem[3], model_mem[0], 1'b0);
    send(1'b0, 4'd0, 4'd3, 4'd0, 16'h0000);
    get_rsp(4, 1'b1, 0);

    // Write 5 <- 1234 with same-transaction readback
    model_mem[5] = 16'h1234;
    push_exp(model_mem[5], model_mem[3], 1'b0);
    send(1'b1, 4'd5, 4'd5, 4'd3, 16'h1234);
    get_rsp(4, 1'b1, 0);

    // Backpressure for 10 cycles with the next command already waiting
    push_exp(model_mem[3], model_mem[5], 1'b0);
    send(1'b0, 4'd0, 4'd3, 4'd5, 16'h0000);
    cmd_we      = 1'b0;
    cmd_addr_r1 = 4'd5;
    cmd_addr_r2 = 4'd3;
    cmd_valid   = 1'b1;
    get_rsp(4, 1'b1, 10);
    push_exp(model_mem[5], model_mem[3], 1'b0);
    send(1'b0, 4'd0, 4'd5, 4'd3, 16'h0000);
    check("accept_after_rsp", 32'(acc_cyc - hs_cyc), 32'd1);
    get_rsp(4, 1'b1, 0);

    // Ack never arrives: req high exactly TO cycles, then a timed-out response
    mode = M_NOACK;
    push_exp(16'h0000, 16'h0000, 1'b1);
    send(1'b1, 4'd4, 4'd3, 4'd5, 16'hDEAD);
    hi = 1;
    do begin
      @(posedge clk);
      #1;
      if (rf_req === 1'b1) hi++;
    end while (rf_req === 1'b1 && hi < 50);
    check("req_high_cycles", 32'(hi), 32'(TO));
    get_rsp(TO + 1, 1'b1, 0);

    // Ack rises on the same edge the timeout would fire: ack wins
    mode      = M_NORMAL;
    ack_delay = TO - 2;
    model_mem[6] = 16'hCAFE;
    push_exp(model_mem[6], model_mem[3], 1'b0);
    send(1'b1, 4'd6, 4'd6, 4'd3, 16'hCAFE);
    get_rsp(TO + 2, 1'b1, 0);
    ack_delay = 0;

    // Ack stuck high: timed-out response, then no acceptance until ack falls
    mode = M_STUCK;
    push_exp(model_mem[3], model_mem[5], 1'b1);
    send(1'b0, 4'd0, 4'd3, 4'd5, 16'h0000);
    get_rsp(TO + 2, 1'b0, 0);
    cmd_we      = 1'b0;
    cmd_addr_r1 = 4'd6;
    cmd_addr_r2 = 4'd5;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stuck_busy", busy, 1'b0);
      check("stuck_cmd_ready", cmd_ready, 1'b0);
    end
    mode = M_NORMAL;
    push_exp(model_mem[6], model_mem[5], 1'b0);
    send(1'b0, 4'd0, 4'd6, 4'd5, 16'h0000);
    get_rsp(4, 1'b1, 0);

    // Reset while in REQ_HI with ack already high
    model_mem[7] = 16'hA5A5;
    send(1'b1, 4'd7, 4'd0, 4'd0, 16'hA5A5);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_req", rf_req, 1'b1);
    mode  = M_STUCK;
    rst_n = 1'b0;
    #1;
    check("midrst_rf_req", rf_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rf_we", rf_we, 1'b0);
    check("midrst_rf_addr_w", rf_addr_w, 4'h0);
    check("midrst_rf_data_in", rf_data_in, 16'h0000);
    check("midrst_rsp_data1", rsp_data1, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_cmd_ready", cmd_ready, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    mode = M_NORMAL;
    push_exp(model_mem[7], model_mem[3], 1'b0);
    send(1'b0, 4'd0, 4'd7, 4'd3, 16'h0000);
    get_rsp(4, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
